spi_fl_master_gen: RTL

//  Parametrised SPI flash master (mode 0), next generation of the single-mode flash master.

---
 rtl/spi_fl_master_gen.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/spi_fl_master_gen.sv
// rtl/spi_fl_master_gen.sv - SPI flash master (mode 0) with divider, dummy cycles, write/read data phases
// and a minimum chip-select gap between transactions.
module spi_fl_master_gen #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 24,
  parameter int CLK_DIV = 2,
  parameter int CS_HIGH = 4,
  parameter int DUMMY_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      ss,
  output logic                      sclk,
  output logic                      mosi,
  input  logic                      miso,
  input  logic [DATA_W-1:0]         data_in,
  output logic [DATA_W-1:0]         data_out,
  input  logic [ADDR_W-1:0]         address,
  input  logic [7:0]                command,
  input  logic [2:0]                commtype,
  input  logic [$clog2(DATA_W):0]   ndata_bits,
  input  logic [DUMMY_W-1:0]        dummy_cycles,
  input  logic                      validflag,
  output logic                      validflag_out,
  output logic                      tready
);

  localparam int NB_W     = $clog2(DATA_W) + 1;
  localparam int MAX_AD   = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int MAX_BITS = (MAX_AD > (1 << DUMMY_W)) ? MAX_AD : (1 << DUMMY_W);
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam int TX_W     = (MAX_AD > 8) ? MAX_AD : 8;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W    = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DUMMY = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_READ  = 3'd5;
  localparam logic [2:0] S_TAIL  = 3'd6;
  localparam logic [2:0] S_GAP   = 3'd7;

  logic [2:0]         state;
  logic [DIV_W-1:0]   div_cnt;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   bit_last;
  logic [GAP_W-1:0]   gap_cnt;
  logic [TX_W-1:0]    tx;
  logic [DATA_W-1:0]  rx;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  din_q;
  logic [NB_W-1:0]    nb_q;
  logic [DUMMY_W-1:0] dcyc_q;
  logic               has_addr, has_dummy, has_wr, has_rd;

  logic [2:0]         ct;
  logic [NB_W-1:0]    nb_clamp;
  logic [TX_W-1:0]    cmd_tx;
  logic [2:0]         nxt_state;
  logic [CNT_W-1:0]   nxt_last;
  logic [TX_W-1:0]    nxt_tx;
  logic               go_addr, go_dummy, go_data, in_shift;

  always_comb begin
    ct       = (commtype == 3'b111) ? 3'b000 : commtype;
    nb_clamp = (ndata_bits > NB_W'(DATA_W)) ? NB_W'(DATA_W) : ndata_bits;
    cmd_tx   = '0;
    cmd_tx[TX_W-1 -: 8] = command;
  end

  // Successor phase chosen at the last bit of the current one; absent phases are skipped.
  always_comb begin
    nxt_state = S_TAIL;
    nxt_last  = '0;
    nxt_tx    = '0;
    go_addr   = (state == S_CMD) && has_addr;
    go_dummy  = (state == S_ADDR) && has_dummy && (dcyc_q != '0);
    go_data   = !go_addr && !go_dummy && (nb_q != '0) && (has_wr || has_rd) &&
                ((state == S_CMD) || (state == S_ADDR) || (state == S_DUMMY));
    if (go_addr) begin
      nxt_state = S_ADDR;
      nxt_last  = CNT_W'(ADDR_W - 1);
      nxt_tx[TX_W-1 -: ADDR_W] = addr_q;
    end else if (go_dummy) begin
      nxt_state = S_DUMMY;
      nxt_last  = CNT_W'(dcyc_q) - CNT_W'(1);
    end else if (go_data) begin
      nxt_state = has_wr ? S_WRITE : S_READ;
      nxt_last  = CNT_W'(nb_q) - CNT_W'(1);
      if (has_wr) nxt_tx[TX_W-1 -: DATA_W] = din_q;
    end
  end

  assign in_shift = (state == S_CMD) || (state == S_ADDR) || (state == S_DUMMY) ||
                    (state == S_WRITE) || (state == S_READ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      ss            <= 1'b1;
      sclk          <= 1'b0;
      mosi          <= 1'b0;
      tready        <= 1'b1;
      validflag_out <= 1'b0;
      data_out      <= '0;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      bit_last      <= '0;
      gap_cnt       <= '0;
      tx            <= '0;
      rx            <= '0;
      addr_q        <= '0;
      din_q         <= '0;
      nb_q          <= '0;
      dcyc_q        <= '0;
      has_addr      <= 1'b0;
      has_dummy     <= 1'b0;
      has_wr        <= 1'b0;
      has_rd        <= 1'b0;
    end else begin
      validflag_out <= 1'b0;
      if (state == S_IDLE) begin
        if (validflag) begin
          state     <= S_CMD;
          tready    <= 1'b0;
          ss        <= 1'b0;
          sclk      <= 1'b0;
          mosi      <= command[7];
          tx        <= cmd_tx;
          bit_cnt   <= '0;
          bit_last  <= CNT_W'(7);
          div_cnt   <= '0;
          rx        <= '0;
          addr_q    <= address;
          din_q     <= data_in;
          nb_q      <= nb_clamp;
          dcyc_q    <= dummy_cycles;
          has_addr  <= (ct == 3'd2) || (ct == 3'd3) || (ct == 3'd5) || (ct == 3'd6);
          has_dummy <= (ct == 3'd6);
          has_wr    <= (ct == 3'd4) || (ct == 3'd5);
          has_rd    <= (ct == 3'd1) || (ct == 3'd3) || (ct == 3'd6);
        end
      end else if (in_shift) begin
        if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
          div_cnt <= '0;
          if (!sclk) begin
            sclk <= 1'b1;
            if (state == S_READ) rx <= {rx[DATA_W-2:0], miso};
          end else begin
            // Falling sclk marks the bit boundary: present the next bit on mosi.
            sclk <= 1'b0;
            if (bit_cnt == bit_last) begin
              state    <= nxt_state;
              bit_cnt  <= '0;
              bit_last <= nxt_last;
              tx       <= nxt_tx;
              mosi     <= nxt_tx[TX_W-1];
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              tx      <= {tx[TX_W-2:0], 1'b0};
              mosi    <= tx[TX_W-2];
            end
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end else if (state == S_TAIL) begin
        if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
          div_cnt <= '0;
          ss      <= 1'b1;
          gap_cnt <= '0;
          state   <= S_GAP;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end else begin
        if (gap_cnt == GAP_W'(CS_HIGH - 1)) begin
          state         <= S_IDLE;
          tready        <= 1'b1;
          validflag_out <= 1'b1;
          if (has_rd) data_out <= rx;
        end else begin
          gap_cnt <= gap_cnt + GAP_W'(1);
        end
      end
    end
  end

endmodule
